csi2_frame_ctrl: RTL

Packet-level sequencer that sits between the CSI-2 header decoder and the RAW10 pixel serializer. It consumes decoded packet headers and their 40-bit payload beats, and tracks frame state from FS/FE short packets. It forwards only in-frame RAW10 long-packet payload to the serializer, with a generated line-end tlast, and drives the serializer's frame-start pulse. All other payload is discarded, and protocol errors are flagged.

---
 rtl/axi4_stream_if.sv | 31 +++
 rtl/csi2_frame_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle shared by the CSI-2 packet path.
// Signals: tdata/tvalid/tready handshake plus tlast, tuser, tstrb, tkeep, tid, tdest sidebands.
// Modports: master drives everything except tready; slave drives only tready.
interface axi4_stream_if #(
  parameter int unsigned DataW = 40,
  parameter int unsigned IdW   = 1,
  parameter int unsigned DestW = 1,
  parameter int unsigned UserW = 1
) ();
  localparam int unsigned StrbW = DataW / 8;

  logic [DataW-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic [UserW-1:0] tuser;
  logic [StrbW-1:0] tstrb;
  logic [StrbW-1:0] tkeep;
  logic [IdW-1:0]   tid;
  logic [DestW-1:0] tdest;

  modport master (
    output tdata, tvalid, tlast, tuser, tstrb, tkeep, tid, tdest,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast, tuser, tstrb, tkeep, tid, tdest,
    output tready
  );
endinterface

// File: rtl/csi2_frame_ctrl.sv
// CSI-2 packet sequencer between the header decoder and the RAW10 serializer.
// Tracks frame state from FS/FE short packets, forwards in-frame RAW10 long-packet payload with a
// generated line-end tlast, discards all other payload and flags protocol errors.
// Ports:
//   clk_i, srst_i                 clock, synchronous active-high reset
//   hdr_valid_i/hdr_ready_o       decoded header handshake, hdr_dt_i data type, hdr_wc_i word count
//   pld_i (slave)                 40-bit payload beats of the current long packet
//   pld_o (master)                forwarded payload to the serializer, tlast marks line end
//   frame_start_o, frame_end_o    one-cycle frame pulses
//   in_frame_o                    high between FS and FE
//   line_cnt_o, frame_lines_o     lines forwarded this frame / latched at the last FE
//   err_wc_o, err_unexp_o         one-cycle error pulses
module csi2_frame_ctrl #(
  parameter logic [5:0]  RAW_DT         = 6'h2B,
  parameter int unsigned BYTES_PER_BEAT = 5,
  parameter int unsigned LINE_CNT_W     = 16
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  hdr_valid_i,
  output logic                  hdr_ready_o,
  input  logic [5:0]            hdr_dt_i,
  input  logic [15:0]           hdr_wc_i,
  axi4_stream_if.slave          pld_i,
  axi4_stream_if.master         pld_o,
  output logic                  frame_start_o,
  output logic                  frame_end_o,
  output logic                  in_frame_o,
  output logic [LINE_CNT_W-1:0] line_cnt_o,
  output logic [LINE_CNT_W-1:0] frame_lines_o,
  output logic                  err_wc_o,
  output logic                  err_unexp_o
);
  localparam logic [5:0]  DtFs      = 6'h00;
  localparam logic [5:0]  DtFe      = 6'h01;
  localparam logic [5:0]  DtLongMin = 6'h10;
  localparam logic [15:0] BeatBytes = 16'(BYTES_PER_BEAT);

  typedef enum logic [1:0] {StIdle, StPass, StDrop} state_e;

  state_e                state_q;
  logic [15:0]           rem_q;
  logic                  in_frame_q;
  logic [LINE_CNT_W-1:0] line_cnt_q;
  logic [LINE_CNT_W-1:0] frame_lines_q;
  logic                  frame_start_q;
  logic                  frame_end_q;
  logic                  err_wc_q;
  logic                  err_unexp_q;

  logic beat_fire;
  logic last_beat;
  logic wc_aligned;

  // Remaining bytes fit in this beat, so it ends the packet.
  assign last_beat  = (rem_q <= BeatBytes);
  // Constant modulus: folds to fixed logic, no iterative divider.
  assign wc_aligned = ((hdr_wc_i % BeatBytes) == 16'd0);
  assign beat_fire  = pld_i.tvalid && pld_i.tready;

  assign hdr_ready_o   = (state_q == StIdle);
  assign frame_start_o = frame_start_q;
  assign frame_end_o   = frame_end_q;
  assign in_frame_o    = in_frame_q;
  assign line_cnt_o    = line_cnt_q;
  assign frame_lines_o = frame_lines_q;
  assign err_wc_o      = err_wc_q;
  assign err_unexp_o   = err_unexp_q;

  assign pld_o.tuser = '0;
  assign pld_o.tstrb = '1;
  assign pld_o.tkeep = '1;
  assign pld_o.tid   = '0;
  assign pld_o.tdest = '0;

  // Zero-latency pass-through in PASS; DROP sinks beats; IDLE stalls the payload source.
  always_comb begin
    pld_o.tdata  = pld_i.tdata;
    pld_o.tvalid = 1'b0;
    pld_o.tlast  = 1'b0;
    pld_i.tready = 1'b0;
    unique case (state_q)
      StPass: begin
        pld_o.tvalid = pld_i.tvalid;
        pld_o.tlast  = last_beat;
        pld_i.tready = pld_o.tready;
      end
      StDrop:  pld_i.tready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q       <= StIdle;
      rem_q         <= '0;
      in_frame_q    <= 1'b0;
      line_cnt_q    <= '0;
      frame_lines_q <= '0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      err_wc_q      <= 1'b0;
      err_unexp_q   <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      err_wc_q      <= 1'b0;
      err_unexp_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (hdr_valid_i) begin
            if (hdr_dt_i < DtLongMin) begin
              if (hdr_dt_i == DtFs) begin
                // A repeated FS restarts the frame and is also reported.
                err_unexp_q   <= in_frame_q;
                in_frame_q    <= 1'b1;
                line_cnt_q    <= '0;
                frame_start_q <= 1'b1;
              end else if (hdr_dt_i == DtFe) begin
                if (in_frame_q) begin
                  frame_end_q   <= 1'b1;
                  frame_lines_q <= line_cnt_q;
                  in_frame_q    <= 1'b0;
                end else begin
                  err_unexp_q <= 1'b1;
                end
              end
            end else begin
              rem_q <= hdr_wc_i;
              if (hdr_wc_i == 16'd0) begin
                err_wc_q <= (hdr_dt_i == RAW_DT);
              end else if (hdr_dt_i != RAW_DT) begin
                state_q <= StDrop;
              end else if (!in_frame_q) begin
                err_unexp_q <= 1'b1;
                state_q     <= StDrop;
              end else if (!wc_aligned) begin
                err_wc_q <= 1'b1;
                state_q  <= StDrop;
              end else begin
                state_q <= StPass;
              end
            end
          end
        end
        StPass, StDrop: begin
          if (beat_fire) begin
            rem_q <= last_beat ? 16'd0 : (rem_q - BeatBytes);
            if (last_beat) begin
              state_q <= StIdle;
              if ((state_q == StPass) && (line_cnt_q != '1)) begin
                line_cnt_q <= line_cnt_q + LINE_CNT_W'(1);
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
